// File: rtl/aes_key_expand_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the AES-128 key schedule.
package aes_key_expand_pkg;

  localparam int unsigned WORD_SIZE  = 8;
  localparam int unsigned ARRAY_SIZE = 16;
  localparam int unsigned KEY_W      = WORD_SIZE * ARRAY_SIZE;
  localparam int unsigned COL_W      = 4 * WORD_SIZE;
  localparam int unsigned NR         = 10;

  localparam logic [7:0] AES_RCON_INIT  = 8'h01;
  localparam logic [7:0] AES_XTIME_POLY = 8'h1B;

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_XTIME_POLY : 8'h00);
  endfunction

  // Column c of a key as a word, with the lowest-numbered byte as the MSB.
  function automatic logic [COL_W-1:0] get_col(input logic [KEY_W-1:0] k,
                                               input int unsigned      c);
    logic [COL_W-1:0] col;
    col = '0;
    for (int unsigned j = 0; j < 4; j++)
      col[COL_W-1-8*j -: 8] = k[8*(4*c+j) +: 8];
    return col;
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Handshake and data bundle between the key-schedule controller and aes_key_expand.
interface aes_key_expand_if;
  import aes_key_expand_pkg::*;

  logic             start;
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] round_key;
  logic [3:0]       round_num;
  logic             key_valid;
  logic             key_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, key_in, key_ready,
    input  round_key, round_num, key_valid, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output round_key, round_num, key_valid, busy, done
  );

endinterface

// File: rtl/aes_key_expand_sbox.sv
// Forward AES S-box, purely combinational; shared with the SubBytes stage.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Row 0 sits in the MSBs, so entry i lives at bit offset (255-i)*8.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_idx;

  assign w_idx  = {~i_byte, 3'b000};
  assign o_byte = SBOX[w_idx +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: holds one round key and derives the next in a single cycle.
module aes_key_expand
  import aes_key_expand_pkg::*;
(
  input logic           clk,
  input logic           rst,
  aes_key_expand_if.slave bus
);

  state_t           r_state;
  logic [KEY_W-1:0] r_round_key;
  logic [3:0]       r_round_num;
  logic             r_key_valid;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_rcon;

  logic [COL_W-1:0] w_w3;
  logic [COL_W-1:0] w_rot;
  logic [COL_W-1:0] w_sub;
  logic [COL_W-1:0] w_t;
  logic [KEY_W-1:0] w_next;
  logic             w_fire;

  assign w_w3   = get_col(r_round_key, 3);
  assign w_rot  = {w_w3[23:0], w_w3[31:24]};
  assign w_t    = w_sub ^ {r_rcon, 24'h000000};
  assign w_fire = r_key_valid & bus.key_ready;

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  // Word XOR chain: each new column is the old column XOR the previous new column.
  always_comb begin
    logic [COL_W-1:0] v_prev;
    logic [COL_W-1:0] v_cur;
    w_next = '0;
    v_prev = w_t;
    v_cur  = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      v_cur = get_col(r_round_key, c) ^ v_prev;
      for (int unsigned j = 0; j < 4; j++)
        w_next[8*(4*c+j) +: 8] = v_cur[COL_W-1-8*j -: 8];
      v_prev = v_cur;
    end
  end

  // Control FSM with registered round key, rcon and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_round_key <= '0;
      r_round_num <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rcon      <= AES_RCON_INIT;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_round_key <= bus.key_in;
            r_round_num <= '0;
            r_key_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_rcon      <= AES_RCON_INIT;
            r_state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_fire) begin
            if (r_round_num < 4'(NR)) begin
              r_round_key <= w_next;
              r_round_num <= r_round_num + 4'd1;
              r_rcon      <= xtime(r_rcon);
            end else begin
              r_key_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.round_key = r_round_key;
  assign bus.round_num = r_round_num;
  assign bus.key_valid = r_key_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 A.1, zero key, backpressure, start handling, async reset.
module tb_aes_key_expand;

  logic clk;
  logic rst;

  aes_key_expand_if bus_if ();

  aes_key_expand dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_vec;
  int n_err;

  // FIPS-197 A.1 round keys 0..10, written in FIPS byte order (first byte leftmost).
  logic [127:0] a1 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  logic [127:0] z1  = 128'h62636363626363636263636362636363;
  logic [127:0] z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIPS string order -> port layout (byte n at bits [8n+7:8n]).
  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = h[127-8*i -: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_round(input string tag, input int r, input logic [127:0] key_fips);
    chk({tag, "_valid"}, 128'(bus_if.key_valid), 128'd1);
    chk({tag, "_num"},   128'(bus_if.round_num), 128'(r));
    chk({tag, "_key"},   bus_if.round_key, fips(key_fips));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  idx;
    int  cyc;
    logic rdy;

    n_vec = 0;
    n_err = 0;
    rst              = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.key_in    = '0;
    bus_if.key_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(bus_if.key_valid), 128'd0);
    chk("rst_busy",  128'(bus_if.busy),      128'd0);
    chk("rst_done",  128'(bus_if.done),      128'd0);
    chk("rst_num",   128'(bus_if.round_num), 128'd0);
    chk("rst_key",   bus_if.round_key,       128'd0);
    rst = 1'b1;

    // Idle: no start for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_valid", 128'(bus_if.key_valid), 128'd0);
      chk("idle_busy",  128'(bus_if.busy),      128'd0);
      chk("idle_done",  128'(bus_if.done),      128'd0);
    end

    // FIPS-197 A.1 with key_ready held high
    bus_if.key_in = fips(a1[0]);
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("a1_busy", 128'(bus_if.busy), 128'd1);
    for (int r = 0; r <= 10; r++) begin
      chk_round("a1", r, a1[r]);
      @(negedge clk);
    end
    chk("a1_done",       128'(bus_if.done),      128'd1);
    chk("a1_done_valid", 128'(bus_if.key_valid), 128'd0);
    chk("a1_done_busy",  128'(bus_if.busy),      128'd0);
    @(negedge clk);
    chk("a1_done_pulse", 128'(bus_if.done), 128'd0);

    // Backpressure: pseudo-random key_ready, each round must appear once and hold
    bus_if.key_in = fips(a1[0]);
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 11 && cyc < 300) begin
      chk_round("bp", idx, a1[idx]);
      chk("bp_done_low", 128'(bus_if.done), 128'd0);
      rdy = 1'($urandom_range(0, 1));
      bus_if.key_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) idx++;
    end
    chk("bp_all_rounds", 128'(idx), 128'd11);
    chk("bp_done", 128'(bus_if.done), 128'd1);
    bus_if.key_ready = 1'b1;
    @(negedge clk);

    // All-zero key
    bus_if.key_in = '0;
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk_round("z0", 0, 128'd0);
    @(negedge clk);
    chk_round("z1", 1, z1);
    repeat (9) @(negedge clk);
    chk_round("z10", 10, z10);
    @(negedge clk);
    chk("z_done", 128'(bus_if.done), 128'd1);
    @(negedge clk);

    // start during EMIT is ignored; start in the done cycle is accepted
    bus_if.key_in = fips(a1[0]);
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (4) @(negedge clk);
    chk_round("ign4", 4, a1[4]);
    bus_if.key_in = fips(128'h00112233445566778899aabbccddeeff);
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk_round("ign5", 5, a1[5]);
    repeat (5) @(negedge clk);
    chk_round("ign10", 10, a1[10]);
    @(negedge clk);
    chk("b2b_done", 128'(bus_if.done), 128'd1);
    bus_if.key_in = '0;
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk_round("b2b0", 0, 128'd0);
    chk("b2b0_done", 128'(bus_if.done), 128'd0);
    @(negedge clk);
    chk_round("b2b1", 1, z1);
    repeat (5) @(negedge clk);
    chk("pre_rst_num", 128'(bus_if.round_num), 128'd6);

    // Asynchronous reset in the middle of round 6, away from any clock edge
    bus_if.key_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 128'(bus_if.key_valid), 128'd0);
    chk("arst_busy",  128'(bus_if.busy),      128'd0);
    chk("arst_done",  128'(bus_if.done),      128'd0);
    chk("arst_num",   128'(bus_if.round_num), 128'd0);
    chk("arst_key",   bus_if.round_key,       128'd0);
    @(negedge clk);
    chk("arst_hold_valid", 128'(bus_if.key_valid), 128'd0);
    rst = 1'b1;
    bus_if.key_ready = 1'b1;
    bus_if.key_in = fips(a1[0]);
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk_round("rs0", 0, a1[0]);
    @(negedge clk);
    chk_round("rs1", 1, a1[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Iterative AES-128 key schedule feeding the round-key port of the AddRoundKey stage. It loads a 128-bit cipher key and emits round keys 0..10 in order, one per valid/ready handshake. Each next round key is computed in a single cycle from the current one. Only the current round key is stored, so no 176-byte schedule RAM is needed.

Parameters:
word_size, 8, bits per byte lane
array_size, 16, bytes per block/key
NR, 10, number of rounds; only 10 (AES-128) is supported

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  load key_in and begin a schedule; sampled only in IDLE
key_in  in  word_size*array_size  cipher key; byte n (FIPS order) at bits [8n+7:8n]
round_key  out  word_size*array_size  current round key, same byte layout as key_in; drives AddRoundKey key port directly
round_num  out  4  index (0..10) of round_key
key_valid  out  1  round_key/round_num are valid
key_ready  in  1  consumer accepts round_key this cycle
busy  out  1  schedule in progress (not IDLE)
done  out  1  one-cycle pulse after round 10 is accepted

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (rst low, asynchronous): round_key=0, round_num=0, key_valid=0, busy=0, done=0, FSM=IDLE. Reset mid-schedule aborts with no further output.
- FSM states: IDLE, EMIT.
- IDLE:
  - On start=1 at a rising edge: round_key<=key_in, round_num<=0, key_valid<=1, busy<=1, go to EMIT. Round 0 is therefore valid 1 cycle after start.
  - start=0: hold.
- EMIT, handshake (key_valid & key_ready at a rising edge):
  - If round_num<10: round_key<=next(round_key), round_num<=round_num+1, key_valid stays 1. There is no bubble, so one key per cycle is possible with key_ready tied high.
  - If round_num==10: key_valid<=0, busy<=0, done<=1 for exactly one cycle, go to IDLE.
- EMIT, no handshake: round_key, round_num and key_valid are held stable.
- start while in EMIT is ignored.
- In the IDLE cycle where done=1, start is accepted normally.
- Last-round timing with key_ready held high from round 0: round 10 is accepted at edge start+11, and done is high in the cycle after that edge.
- next() function, words w0..w3 where wc = {byte4c, byte4c+1, byte4c+2, byte4c+3} with byte4c the FIPS most significant byte:
  - t = SubWord(RotWord(w3)) XOR {rcon,0,0,0}
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'
- RotWord maps {a,b,c,d} to {b,c,d,a}. SubWord applies the AES S-box to each byte.
- rcon is an 8-bit register: 01 on load, updated with xtime (shift left 1, XOR 1B if bit 7 was set) on every advancing handshake. Sequence: 01,02,04,08,10,20,40,80,1B,36.
- All arithmetic is GF(2^8) XOR only; there are no carries.

Decomposition:
- Shared package/include, alongside the existing mod helper: AES_RCON_INIT=8'h01, AES_XTIME_POLY=8'h1B, NR=10, and byte/word width constants.
- Sub-module aes_sbox: combinational 8-bit in, 8-bit out forward S-box, instantiated 4 times for SubWord. The same module is reusable by the SubBytes stage.
- FSM, rcon register and word XOR chain stay in aes_key_expand.

Test Plan:
- FIPS-197 A.1: key bytes 2b7e151628aed2a6abf7158809cf4f3c, key_ready=1 -> round 0 equals key_in; round 1 bytes a0fafe1788542cb123a339392a6c7605; round 10 bytes d014f9a8c9ee2589e13f0cc8b6630ca6; done pulse one cycle after the round-10 handshake.
- Backpressure: key_ready toggled pseudo-randomly -> round_key/round_num stable while key_valid & !key_ready; sequence matches the previous test, each round emitted exactly once.
- All-zero key -> round 1 bytes 62636363626363636263636362636363, round 10 bytes b4ef5bcb3e92e21123e951cf6f8f188e.
- start pulsed during EMIT at round 4 with a different key_in -> ignored, schedule continues unchanged. Back-to-back start in the done cycle -> new round 0 valid the next cycle.
- rst driven low asynchronously mid-round 6 (not on a clock edge) -> key_valid, busy, done, round_num and round_key are 0 immediately. After release, start restarts cleanly at round 0.
- Idle checks: start=0 for 20 cycles after reset -> key_valid=0, busy=0, done never asserted.
